// File: rtl/operand_join.sv
// operand_join: joins two valid/ready operand streams into one paired stream.
// Each operand is buffered in its own small FIFO so skewed arrivals pair in
// order. A start/done sequencer emits num_pairs pairs per run (0 = unlimited).
// Operand 2 can be replaced by const_value when const_en is set.
//
// Optional feature macro: OPERAND_JOIN_BYPASS_EN
//   defined   -> empty FIFO with valid input forwards din straight to dout
//   undefined -> no combinational din->dout path (1-cycle minimum latency)
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle pulse, begins a run from IDLE/DONE
//   num_pairs[15:0]       pairs per run, sampled on accepted start
//   const_en, const_value operand 2 override
//   din_1/2, din_1/2_v    operand streams in
//   din_1/2_r             operand ready out
//   dout_1/2, dout_v      paired operands out
//   dout_r                downstream ready
//   pair_count[15:0]      pairs emitted in current run
//   done                  run complete

// Per-operand FIFO; storage cleared on reset so the head reads 0 out of reset.
module operand_join_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

module operand_join #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           num_pairs,
  input  logic                  const_en,
  input  logic [DATA_WIDTH-1:0] const_value,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic                  din_1_v,
  output logic                  din_1_r,
  input  logic [DATA_WIDTH-1:0] din_2,
  input  logic                  din_2_v,
  output logic                  din_2_r,
  output logic [DATA_WIDTH-1:0] dout_1,
  output logic [DATA_WIDTH-1:0] dout_2,
  output logic                  dout_v,
  input  logic                  dout_r,
  output logic [15:0]           pair_count,
  output logic                  done
);
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   num_q, num_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q;
  logic            flush;

  logic            run;
  logic            fire;
  logic            push_1, pop_1, empty_1, full_1, avail_1;
  logic            push_2, pop_2, empty_2, full_2, avail_2;
  logic [DATA_WIDTH-1:0] rdata_1, rdata_2, data_1, data_2;

  assign run = (state_q == S_RUN);

  operand_join_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .push_i (push_1),
    .wdata_i(din_1),
    .pop_i  (pop_1),
    .rdata_o(rdata_1),
    .empty_o(empty_1),
    .full_o (full_1)
  );

  operand_join_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .push_i (push_2),
    .wdata_i(din_2),
    .pop_i  (pop_2),
    .rdata_o(rdata_2),
    .empty_o(empty_2),
    .full_o (full_2)
  );

  // Readiness depends only on FIFO occupancy, never on dout_r.
  assign din_1_r = run && !full_1;
  assign din_2_r = run && !full_2 && !const_en;

  assign dout_v = run && avail_1 && (avail_2 || const_en);
  assign fire   = dout_v && dout_r;
  assign dout_1 = data_1;
  assign dout_2 = const_en ? const_value : data_2;

`ifdef OPERAND_JOIN_BYPASS_EN
  logic byp_1, byp_2;

  // Empty FIFO with a valid input forwards that input; it is not stored if consumed.
  assign byp_1   = run && empty_1 && din_1_v;
  assign byp_2   = run && empty_2 && din_2_v && !const_en;
  assign avail_1 = !empty_1 || byp_1;
  assign avail_2 = !empty_2 || byp_2;
  assign data_1  = empty_1 ? din_1 : rdata_1;
  assign data_2  = empty_2 ? din_2 : rdata_2;
  assign push_1  = din_1_v && din_1_r && !(byp_1 && fire);
  assign push_2  = din_2_v && din_2_r && !(byp_2 && fire);
  assign pop_1   = fire && !empty_1;
  assign pop_2   = fire && !const_en && !empty_2;
`else
  assign avail_1 = !empty_1;
  assign avail_2 = !empty_2;
  assign data_1  = rdata_1;
  assign data_2  = rdata_2;
  assign push_1  = din_1_v && din_1_r;
  assign push_2  = din_2_v && din_2_r;
  assign pop_1   = fire;
  assign pop_2   = fire && !const_en;
`endif

  // Sequencer next state: start flushes and rearms, fires count toward num_pairs.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          num_d   = num_pairs;
          cnt_d   = '0;
          flush   = 1'b1;
        end
      end
      S_RUN: begin
        if (fire) begin
          cnt_d = cnt_q + CW'(1);
          if ((num_q != '0) && (cnt_q + CW'(1) == num_q)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  assign pair_count = cnt_q;
  assign done       = done_q;
endmodule

// File: tb/tb_operand_join.sv
// Scoreboard bench for operand_join: stream drivers feed operands from queues,
// expected pairs are queued at stimulus time and a monitor checks every fire.
module tb_operand_join;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  logic          clk, rst_n, start, const_en, dout_r;
  logic [15:0]   num_pairs, pair_count;
  logic [DW-1:0] const_value, din_1, din_2, dout_1, dout_2;
  logic          din_1_v, din_2_v, din_1_r, din_2_r, dout_v, done;

  operand_join #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pairs(num_pairs),
    .const_en(const_en), .const_value(const_value),
    .din_1(din_1), .din_1_v(din_1_v), .din_1_r(din_1_r),
    .din_2(din_2), .din_2_v(din_2_v), .din_2_r(din_2_r),
    .dout_1(dout_1), .dout_2(dout_2), .dout_v(dout_v), .dout_r(dout_r),
    .pair_count(pair_count), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  pair_t         exp_q[$];
  int            fire_q[$];
  bit            wrap_phase = 0;
  bit            saw_wrap   = 0;
  bit            saw_done   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Stream 1 driver: present queue head, pop on handshake sampled at negedge.
  initial begin
    bit acc;
    din_1_v = 1'b0;
    din_1   = '0;
    forever begin
      @(negedge clk);
      acc = din_1_v && din_1_r;
      @(posedge clk);
      if (acc && q1.size() > 0) void'(q1.pop_front());
      #2;
      if (!rst_n || q1.size() == 0) din_1_v = 1'b0;
      else begin
        din_1_v = 1'b1;
        din_1   = q1[0];
      end
    end
  end

  // Stream 2 driver.
  initial begin
    bit acc;
    din_2_v = 1'b0;
    din_2   = '0;
    forever begin
      @(negedge clk);
      acc = din_2_v && din_2_r;
      @(posedge clk);
      if (acc && q2.size() > 0) void'(q2.pop_front());
      #2;
      if (!rst_n || q2.size() == 0) din_2_v = 1'b0;
      else begin
        din_2_v = 1'b1;
        din_2   = q2[0];
      end
    end
  end

  // Monitor: pop expected pair on every fire and compare.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (rst_n && dout_v && dout_r) begin
        if (exp_q.size() == 0) chk("unexpected_pair", {dout_1, dout_2}, 64'h0);
        else begin
          e = exp_q.pop_front();
          chk("pair", {dout_1, dout_2}, {e.a, e.b});
        end
        fire_q.push_back(cyc_cnt);
      end
      if (rst_n && const_en) chk("din_2_r_const", {63'h0, din_2_r}, 64'h0);
      if (wrap_phase) begin
        if (done) saw_done = 1;
        if (pair_count == 16'h0 && fire_q.size() > 1000) saw_wrap = 1;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] n, input logic ce);
    start     = 1'b1;
    num_pairs = n;
    const_en  = ce;
    tick(1);
    start     = 1'b0;
    num_pairs = 16'hDEAD;
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit use2);
    q1.push_back(a);
    if (use2) q2.push_back(b);
    exp_q.push_back({a, b});
  endtask

  task automatic wait_done(input string name, input int max);
    int i;
    i = 0;
    while (!done && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(name, {63'h0, done}, 64'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_pairs   = '0;
    const_en    = 1'b0;
    const_value = 32'h64;
    dout_r      = 1'b1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout_v", {63'h0, dout_v}, 64'h0);
    chk("rst_din_1_r", {63'h0, din_1_r}, 64'h0);
    chk("rst_din_2_r", {63'h0, din_2_r}, 64'h0);
    chk("rst_pair_count", {48'h0, pair_count}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_dout", {dout_1, dout_2}, 64'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("idle_dout_v", {63'h0, dout_v}, 64'h0);

    // Basic run: three pairs at full rate
    do_start(16'd3, 1'b0);
    chk("run_din_1_r", {63'h0, din_1_r}, 64'h1);
    fire_q.delete();
    push_pair(32'd1, 32'd10, 1);
    push_pair(32'd2, 32'd20, 1);
    push_pair(32'd3, 32'd30, 1);
    wait_done("basic_done", 20);
    chk("basic_fires", 64'(fire_q.size()), 64'd3);
    if (fire_q.size() == 3) begin
      chk("basic_consecutive", 64'(fire_q[2] - fire_q[0]), 64'd2);
      chk("basic_done_timing", 64'(cyc_cnt), 64'(fire_q[2] + 1));
    end
    chk("basic_pair_count", {48'h0, pair_count}, 64'd3);
    chk("basic_dout_v_at_done", {63'h0, dout_v}, 64'h0);
    tick(1);

    // Skew: operand 2 arrives four cycles late
    do_start(16'd2, 1'b0);
    fire_q.delete();
    q1.push_back(32'd5);
    q1.push_back(32'd6);
    exp_q.push_back({32'd5, 32'd7});
    exp_q.push_back({32'd6, 32'd8});
    tick(4);
    chk("skew_din_1_accepted", 64'(q1.size()), 64'd0);
    chk("skew_no_early_pair", 64'(fire_q.size()), 64'd0);
    q2.push_back(32'd7);
    q2.push_back(32'd8);
    wait_done("skew_done", 20);
    chk("skew_pair_count", {48'h0, pair_count}, 64'd2);
    tick(1);

    // Backpressure: dout_r low while both streams are offered
    dout_r = 1'b0;
    do_start(16'd4, 1'b0);
    fire_q.delete();
    for (int i = 0; i < 4; i++) push_pair(32'(11 + i), 32'(21 + i), 1);
    tick(6);
    chk("bp_accepts_1", 64'(q1.size()), 64'd2);
    chk("bp_accepts_2", 64'(q2.size()), 64'd2);
    chk("bp_din_1_r", {63'h0, din_1_r}, 64'h0);
    chk("bp_din_2_r", {63'h0, din_2_r}, 64'h0);
    chk("bp_no_fire", 64'(fire_q.size()), 64'd0);
    dout_r = 1'b1;
    wait_done("bp_done", 30);
    chk("bp_pair_count", {48'h0, pair_count}, 64'd4);
    tick(1);

    // Constant operand 2
    do_start(16'd2, 1'b1);
    push_pair(32'd1, 32'h64, 0);
    push_pair(32'd2, 32'h64, 0);
    wait_done("const_done", 20);
    chk("const_pair_count", {48'h0, pair_count}, 64'd2);
    tick(1);

    // Unlimited run: 70000 pairs, pair_count wraps, never done
    do_start(16'd0, 1'b0);
    fire_q.delete();
    wrap_phase = 1;
    for (int i = 0; i < 70000; i++) push_pair(32'(i), ~32'(i), 1);
    begin
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 72000) begin
        tick(1);
        w++;
      end
    end
    tick(2);
    wrap_phase = 0;
    chk("wrap_all_pairs", 64'(exp_q.size()), 64'd0);
    chk("wrap_seen_zero", {63'h0, saw_wrap}, 64'h1);
    chk("wrap_never_done", {63'h0, saw_done}, 64'h0);
    chk("wrap_pair_count", {48'h0, pair_count}, 64'd4464);
    chk("wrap_still_run", {63'h0, din_1_r}, 64'h1);

    // Asynchronous reset mid-run with entries buffered
    dout_r = 1'b0;
    do_start(16'd5, 1'b0);
    q1.push_back(32'd41);
    q1.push_back(32'd42);
    q2.push_back(32'd51);
    q2.push_back(32'd52);
    tick(4);
    chk("pre_rst_dout_v", {63'h0, dout_v}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    chk("arst_dout_v", {63'h0, dout_v}, 64'h0);
    chk("arst_din_r", {62'h0, din_1_r, din_2_r}, 64'h0);
    chk("arst_pair_count", {48'h0, pair_count}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    chk("arst_dout", {dout_1, dout_2}, 64'h0);
    tick(3);
    rst_n  = 1'b1;
    dout_r = 1'b1;
    tick(3);
    chk("post_rst_dout_v", {63'h0, dout_v}, 64'h0);
    chk("post_rst_din_1_r", {63'h0, din_1_r}, 64'h0);
    do_start(16'd1, 1'b0);
    push_pair(32'd99, 32'd77, 1);
    wait_done("post_rst_done", 20);
    chk("post_rst_pair_count", {48'h0, pair_count}, 64'd1);
    tick(1);

`ifdef OPERAND_JOIN_BYPASS_EN
    // Bypass: empty FIFOs and both inputs valid fire in the same cycle
    do_start(16'd1, 1'b0);
    push_pair(32'hA5, 32'h5A, 1);
    begin
      int w;
      w = 0;
      while (!din_1_v && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    chk("bypass_dout_v", {63'h0, dout_v}, 64'h1);
    wait_done("bypass_done", 10);
    tick(1);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
